// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave front end for an SRAM controller: one transfer at a time,
// registered bus responses, single-cycle request handshake towards the controller.
module ahbl_sram_slave_if #(
    parameter int MEM_AWIDTH = 19
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [MEM_AWIDTH-1:0] HADDR,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  ahbsram_req,
    output logic                  ahbsram_write,
    output logic [2:0]            ahbsram_size,
    output logic [MEM_AWIDTH-1:0] ahbsram_addr,
    output logic [31:0]           ahbsram_wdata,
    input  logic                  sramahb_ack,
    input  logic [31:0]           sramahb_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_REQ,
        S_WAIT,
        S_RCAP,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_phase_valid;
    logic                    w_can_accept;
    logic                    w_accept;
    logic                    w_bad_xfer;

    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [31:0]             r_hrdata;
    logic                    r_req;
    logic                    r_write;
    logic [2:0]              r_size;
    logic [MEM_AWIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;

    assign w_phase_valid = HSEL && HREADYIN && (HTRANS inside {2'b10, 2'b11});
    // Only the states that present HREADYOUT=1 may take a new address phase.
    assign w_can_accept  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept      = w_phase_valid && w_can_accept;

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_bad_xfer = 1'b1;
        case (HSIZE)
            3'b000:  w_bad_xfer = 1'b0;
            3'b001:  w_bad_xfer = HADDR[0];
            3'b010:  w_bad_xfer = |HADDR[1:0];
            default: w_bad_xfer = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (!w_accept)       w_next = S_IDLE;
                else if (w_bad_xfer) w_next = S_ERR1;
                else if (HWRITE)     w_next = S_WDATA;
                else                 w_next = S_REQ;
            end
            S_WDATA: w_next = S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT: begin
                if (sramahb_ack) w_next = r_write ? S_DONE : S_RCAP;
            end
            S_RCAP:  w_next = S_DONE;
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_req       <= 1'b0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_next;
            // Bus responses are registered from the next state so they line up with it.
            r_hreadyout <= (w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERR2);
            r_hresp     <= (w_next == S_ERR1) || (w_next == S_ERR2);
            r_req       <= (w_next == S_REQ);
            if (w_accept) begin
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_addr  <= HADDR;
            end
            if (r_state == S_WDATA) r_wdata  <= HWDATA;
            if (r_state == S_RCAP)  r_hrdata <= sramahb_rdata;
        end
    end

    assign HREADYOUT     = r_hreadyout;
    assign HRESP         = r_hresp;
    assign HRDATA        = r_hrdata;
    assign ahbsram_req   = r_req;
    assign ahbsram_write = r_write;
    assign ahbsram_size  = r_size;
    assign ahbsram_addr  = r_addr;
    assign ahbsram_wdata = r_wdata;

endmodule

// File: tb/tb_ahbl_sram_slave_if.sv
// Bench for ahbl_sram_slave_if: directed cycle table, hand-built corner sequences,
// and a randomized run checked against a transaction-timeline model.
module tb_ahbl_sram_slave_if;

    localparam int AW = 19;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          HSEL = 1'b0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'b000;
    logic [AW-1:0] HADDR = '0;
    logic [31:0]   HWDATA = '0;
    logic          HREADYIN = 1'b1;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          ahbsram_req;
    logic          ahbsram_write;
    logic [2:0]    ahbsram_size;
    logic [AW-1:0] ahbsram_addr;
    logic [31:0]   ahbsram_wdata;
    logic          sramahb_ack = 1'b0;
    logic [31:0]   sramahb_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    ahbl_sram_slave_if #(.MEM_AWIDTH(AW)) dut (
        .HCLK          (HCLK),
        .HRESETN       (HRESETN),
        .HSEL          (HSEL),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HADDR         (HADDR),
        .HWDATA        (HWDATA),
        .HREADYIN      (HREADYIN),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .ahbsram_req   (ahbsram_req),
        .ahbsram_write (ahbsram_write),
        .ahbsram_size  (ahbsram_size),
        .ahbsram_addr  (ahbsram_addr),
        .ahbsram_wdata (ahbsram_wdata),
        .sramahb_ack   (sramahb_ack),
        .sramahb_rdata (sramahb_rdata)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic          hsel;
        logic [1:0]    htrans;
        logic          hwrite;
        logic [2:0]    hsize;
        logic [AW-1:0] haddr;
        logic          hreadyin;
        logic [31:0]   hwdata;
        logic          ack;
        logic [31:0]   rdata;
        logic          e_ready;
        logic          e_resp;
        logic          e_req;
        logic [31:0]   e_hrdata;
        logic          chk_attr;
        logic          e_write;
        logic [2:0]    e_size;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                               input logic [2:0] hsize, input logic [AW-1:0] haddr,
                               input logic [31:0] hwdata, input logic ack, input logic [31:0] rdata,
                               input logic e_ready, input logic e_resp, input logic e_req,
                               input logic [31:0] e_hrdata);
        vec_t r;
        r.hsel = hsel;       r.htrans = htrans;   r.hwrite = hwrite;   r.hsize = hsize;
        r.haddr = haddr;     r.hreadyin = 1'b1;   r.hwdata = hwdata;   r.ack = ack;
        r.rdata = rdata;     r.e_ready = e_ready; r.e_resp = e_resp;   r.e_req = e_req;
        r.e_hrdata = e_hrdata;
        r.chk_attr = 1'b0;   r.e_write = 1'b0;    r.e_size = '0;       r.e_addr = '0;
        r.e_wdata = '0;
        return r;
    endfunction

    task automatic set_attr(input int i, input logic w, input logic [2:0] s,
                            input logic [AW-1:0] a, input logic [31:0] wd);
        vt[i].chk_attr = 1'b1;
        vt[i].e_write  = w;
        vt[i].e_size   = s;
        vt[i].e_addr   = a;
        vt[i].e_wdata  = wd;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b000;
        HADDR = '0; HREADYIN = 1'b1; sramahb_ack = 1'b0;
    endtask

    task automatic addr_phase(input logic w, input logic [2:0] s, input logic [AW-1:0] a);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HSIZE = s; HADDR = a; HREADYIN = 1'b1;
    endtask

    // Randomized run. The model turns each accepted address phase into a timeline
    // of expected events (request cycle, ack cycle, completion cycle) using the
    // transfer rules, and compares the bus outputs cycle by cycle.
    task automatic run_random(input int n_cycles);
        int            busy_until = 0;
        int            req_at = -10;
        int            ack_at = -10;
        int            err_at = -10;
        int            rd_done = -10;
        int            wd_at = -10;
        int            lat;
        logic          m_write = 1'b0;
        logic [2:0]    m_size = '0;
        logic [AW-1:0] m_addr = '0;
        logic [31:0]   m_wdata = '0;
        logic [31:0]   m_hrdata = '0;
        logic [31:0]   rd_val = '0;
        logic          bad;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge HCLK);
            if (c == rd_done) m_hrdata = rd_val;
            check("rnd_hreadyout", 32'(HREADYOUT), 32'(c >= busy_until));
            check("rnd_hresp", 32'(HRESP), 32'(c == err_at || c == err_at + 1));
            check("rnd_req", 32'(ahbsram_req), 32'(c == req_at));
            check("rnd_hrdata", HRDATA, m_hrdata);
            if (c == req_at || c == busy_until) begin
                check("rnd_attr_write", 32'(ahbsram_write), 32'(m_write));
                check("rnd_attr_size", 32'(ahbsram_size), 32'(m_size));
                check("rnd_attr_addr", 32'(ahbsram_addr), 32'(m_addr));
                if (m_write) check("rnd_attr_wdata", ahbsram_wdata, m_wdata);
            end

            // Controller side: true ack on schedule, stray acks only where no WAIT is possible.
            if (c == ack_at)                    sramahb_ack = 1'b1;
            else if (c > req_at && c < ack_at)  sramahb_ack = 1'b0;
            else                                sramahb_ack = ($urandom_range(0, 3) == 0);
            sramahb_rdata = (c == ack_at || c == ack_at + 1) ? rd_val : $urandom;
            HWDATA        = (c == wd_at) ? m_wdata : $urandom;

            HSEL     = ($urandom_range(0, 3) != 0);
            HTRANS   = 2'($urandom_range(0, 3));
            HWRITE   = 1'($urandom_range(0, 1));
            HSIZE    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            HADDR    = AW'($urandom);
            if ($urandom_range(0, 3) != 0) HADDR[1:0] = 2'b00;
            HREADYIN = ($urandom_range(0, 7) != 0);

            if (c >= busy_until && HSEL && HREADYIN && HTRANS[1]) begin
                bad = (HSIZE > 3'd2) || ((int'(HADDR) % (1 << int'(HSIZE))) != 0);
                m_write = HWRITE; m_size = HSIZE; m_addr = HADDR;
                if (bad) begin
                    err_at     = c + 1;
                    busy_until = c + 2;
                end else begin
                    lat = $urandom_range(1, 6);
                    if (HWRITE) begin
                        wd_at      = c + 1;
                        m_wdata    = $urandom;
                        req_at     = c + 2;
                        ack_at     = req_at + lat;
                        busy_until = ack_at + 1;
                    end else begin
                        req_at     = c + 1;
                        ack_at     = req_at + lat;
                        busy_until = ack_at + 2;
                        rd_done    = ack_at + 2;
                        rd_val     = $urandom;
                    end
                end
            end
        end
        @(negedge HCLK);
        bus_idle();
    endtask

    initial begin
        int n_req;
        logic [31:0] db;
        db = 32'hDEADBEEF;

        // Cycle table: inputs driven in the cycle, outputs expected in that same cycle.
        vt[0]  = v(1, 2'b10, 1, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, '0);
        vt[1]  = v(0, 2'b00, 0, 3'd0, '0,     db,            0, '0, 0, 0, 0, '0);
        vt[2]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 0, 0, 1, '0);
        vt[3]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            1, '0, 0, 0, 0, '0);
        vt[4]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 1, 0, 0, '0);
        vt[5]  = v(1, 2'b10, 0, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, '0);
        vt[6]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 0, 0, 1, '0);
        vt[7]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            1, db, 0, 0, 0, '0);
        vt[8]  = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, db, 0, 0, 0, '0);
        vt[9]  = v(1, 2'b10, 1, 3'd0, 19'h3,  '0,            0, '0, 1, 0, 0, db);
        vt[10] = v(0, 2'b00, 0, 3'd0, '0,     32'h11223344,  0, '0, 0, 0, 0, db);
        vt[11] = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 0, 0, 1, db);
        vt[12] = v(0, 2'b00, 0, 3'd0, '0,     '0,            1, '0, 0, 0, 0, db);
        vt[13] = v(1, 2'b10, 0, 3'd3, 19'h20, '0,            0, '0, 1, 0, 0, db);
        vt[14] = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 0, 1, 0, db);
        vt[15] = v(1, 2'b10, 0, 3'd1, 19'h1,  '0,            0, '0, 1, 1, 0, db);
        vt[16] = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 0, 1, 0, db);
        vt[17] = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 1, 1, 0, db);
        vt[18] = v(1, 2'b01, 1, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, db);
        vt[19] = v(0, 2'b10, 1, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, db);
        vt[20] = v(1, 2'b10, 1, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, db);
        vt[21] = v(0, 2'b00, 0, 3'd0, '0,     '0,            0, '0, 1, 0, 0, db);
        vt[22] = v(1, 2'b00, 0, 3'd2, 19'h10, '0,            0, '0, 1, 0, 0, db);
        vt[23] = v(0, 2'b00, 0, 3'd0, '0,     '0,            1, '0, 1, 0, 0, db);
        vt[20].hreadyin = 1'b0;
        set_attr(2,  1, 3'd2, 19'h10, db);
        set_attr(6,  0, 3'd2, 19'h10, db);
        set_attr(11, 1, 3'd0, 19'h3,  32'h11223344);
        set_attr(13, 1, 3'd0, 19'h3,  32'h11223344);

        // Reset values while reset is held.
        #12;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_req", 32'(ahbsram_req), 32'd0);
        check("rst_write", 32'(ahbsram_write), 32'd0);
        check("rst_size", 32'(ahbsram_size), 32'd0);
        check("rst_addr", 32'(ahbsram_addr), 32'd0);
        check("rst_wdata", ahbsram_wdata, 32'd0);
        @(negedge HCLK);
        HRESETN = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < NV; i++) begin
            @(negedge HCLK);
            check($sformatf("vec%0d_hreadyout", i), 32'(HREADYOUT), 32'(vt[i].e_ready));
            check($sformatf("vec%0d_hresp", i), 32'(HRESP), 32'(vt[i].e_resp));
            check($sformatf("vec%0d_req", i), 32'(ahbsram_req), 32'(vt[i].e_req));
            check($sformatf("vec%0d_hrdata", i), HRDATA, vt[i].e_hrdata);
            if (vt[i].chk_attr) begin
                check($sformatf("vec%0d_write", i), 32'(ahbsram_write), 32'(vt[i].e_write));
                check($sformatf("vec%0d_size", i), 32'(ahbsram_size), 32'(vt[i].e_size));
                check($sformatf("vec%0d_addr", i), 32'(ahbsram_addr), 32'(vt[i].e_addr));
                check($sformatf("vec%0d_wdata", i), ahbsram_wdata, vt[i].e_wdata);
            end
            HSEL = vt[i].hsel; HTRANS = vt[i].htrans; HWRITE = vt[i].hwrite;
            HSIZE = vt[i].hsize; HADDR = vt[i].haddr; HREADYIN = vt[i].hreadyin;
            HWDATA = vt[i].hwdata; sramahb_ack = vt[i].ack; sramahb_rdata = vt[i].rdata;
        end
        @(negedge HCLK);
        bus_idle();

        // Slow ack: write whose ack arrives 5 cycles after the request, plus a stray ack in WDATA.
        @(negedge HCLK);
        addr_phase(1'b1, 3'd2, 19'h40);
        n_req = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge HCLK);
            if (ahbsram_req) n_req++;
            if (k <= 7) check($sformatf("slow_k%0d_hreadyout", k), 32'(HREADYOUT), 32'd0);
            if (k == 8) begin
                check("slow_done_hreadyout", 32'(HREADYOUT), 32'd1);
                check("slow_done_hresp", 32'(HRESP), 32'd0);
                check("slow_done_wdata", ahbsram_wdata, 32'hCAFEF00D);
                check("slow_done_addr", 32'(ahbsram_addr), 32'h40);
            end
            bus_idle();
            HWDATA = (k == 1) ? 32'hCAFEF00D : $urandom;
            sramahb_ack = (k == 1 || k == 7);
        end
        check("slow_req_count", 32'(n_req), 32'd1);

        // Reset during WAIT of a read, then a late ack after release.
        @(negedge HCLK);
        addr_phase(1'b0, 3'd2, 19'h44);
        @(negedge HCLK);
        bus_idle();
        @(negedge HCLK);
        check("rstw_in_wait", 32'(HREADYOUT), 32'd0);
        #2 HRESETN = 1'b0;
        #1;
        check("rstw_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rstw_req", 32'(ahbsram_req), 32'd0);
        check("rstw_hrdata", HRDATA, 32'd0);
        check("rstw_addr", 32'(ahbsram_addr), 32'd0);
        @(negedge HCLK);
        HRESETN = 1'b1;
        sramahb_ack = 1'b1;
        sramahb_rdata = 32'h55AA55AA;
        n_req = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge HCLK);
            sramahb_ack = 1'b0;
            if (ahbsram_req) n_req++;
            check($sformatf("rstw_after_k%0d_hreadyout", k), 32'(HREADYOUT), 32'd1);
            check($sformatf("rstw_after_k%0d_hrdata", k), HRDATA, 32'd0);
        end
        check("rstw_req_count", 32'(n_req), 32'd0);

        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahbl_sram_slave_if.md
AHBL_SRAM_SLAVE_IF -- requirements
Module: ahbl_sram_slave_if

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 19, meaning SRAM byte-address width.
REQ-002 SHALL have port HCLK  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port HRESETN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port HSEL  in  1  slave select.
REQ-005 SHALL have port HTRANS  in  2  transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have port HWRITE  in  1  1=write.
REQ-007 SHALL have port HSIZE  in  3  transfer size.
REQ-008 SHALL have port HADDR  in  MEM_AWIDTH  byte address.
REQ-009 SHALL have port HWDATA  in  32  write data, valid in data phase.
REQ-010 SHALL have port HREADYIN  in  1  bus ready.
REQ-011 SHALL have port HREADYOUT  out  1  slave ready, registered.
REQ-012 SHALL have port HRESP  out  1  0=OKAY, 1=ERROR, registered.
REQ-013 SHALL have port HRDATA  out  32  read data, registered.
REQ-014 SHALL have port ahbsram_req  out  1  one-cycle access request to the SRAM controller.
REQ-015 SHALL have port ahbsram_write  out  1, ahbsram_size  out  3, ahbsram_addr  out  MEM_AWIDTH, and ahbsram_wdata  out  32; all four are latched transfer attributes.
REQ-016 SHALL have port sramahb_ack  in  1  controller completion pulse.
REQ-017 SHALL have port sramahb_rdata  in  32  controller read data, registered inside the controller.

Function
REQ-018 SHALL sample an address phase only when HSEL=1, HREADYIN=1 and HTRANS[1]=1; it SHALL then latch HWRITE, HSIZE and HADDR.
REQ-019 SHALL implement states IDLE, WDATA, REQ, WAIT, RCAP, DONE, ERR1 and ERR2.
REQ-020 SHALL handle IDLE/BUSY transfers, or HSEL=0, with no SRAM access; HREADYOUT SHALL stay 1 and HRESP SHALL stay 0.
REQ-021 SHALL handle a write as follows: address phase -> WDATA, which latches HWDATA into ahbsram_wdata; WDATA -> REQ, where ahbsram_req=1 for exactly one cycle; REQ -> WAIT; WAIT -> DONE on sramahb_ack=1.
REQ-022 SHALL handle a read as follows: address phase -> REQ; REQ -> WAIT; WAIT -> RCAP on sramahb_ack; RCAP latches sramahb_rdata into HRDATA; RCAP -> DONE.
REQ-023 SHALL drive HREADYOUT=0 in WDATA, REQ, WAIT, RCAP and ERR1, and HREADYOUT=1 in IDLE, DONE and ERR2; a read or write data phase is therefore exactly 4 cycles (3 wait states) given a one-cycle ack latency.
REQ-024 SHALL remain in WAIT with HREADYOUT=0 for any ack latency; ahbsram_req SHALL NOT re-assert while in WAIT.
REQ-025 SHALL hold ahbsram_write, ahbsram_size, ahbsram_addr and ahbsram_wdata stable from REQ until the next address phase is accepted.
REQ-026 SHALL accept a new address phase in DONE or ERR2 (pipelined back-to-back transfer) and go directly to WDATA or REQ; otherwise it SHALL go to IDLE.
REQ-027 SHALL treat HSIZE>3'b010, a halfword with HADDR[0]=1, or a word with HADDR[1:0]!=0 as an error; it SHALL then go ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1), with no ahbsram_req asserted.
REQ-028 SHALL hold HRDATA at its value until the next RCAP; writes and errors SHALL NOT alter HRDATA.
REQ-029 SHALL ignore sramahb_ack outside WAIT.
REQ-030 SHALL ignore HSEL, HTRANS, HADDR, HWRITE and HSIZE while HREADYOUT=0.

Reset
REQ-031 SHALL, on HRESETN=0 and asynchronously, force state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, ahbsram_req=0, ahbsram_write=0, ahbsram_size=0, ahbsram_addr=0 and ahbsram_wdata=0.
REQ-032 SHALL, on reset asserted mid-transfer (WDATA through RCAP), abandon the transfer; after release the block SHALL issue no ahbsram_req until a new valid address phase.

Verification
REQ-033 Word write: HADDR=0x10, HSIZE=010, HWDATA=0xDEADBEEF, ack one cycle after req -> ahbsram_req pulse 2 cycles after the address phase, ahbsram_addr=0x10, ahbsram_wdata=0xDEADBEEF, HREADYOUT low 3 cycles then high, HRESP=0.
REQ-034 Word read: HADDR=0x10, controller returns 0xDEADBEEF -> ahbsram_req 1 cycle after the address phase, HRDATA=0xDEADBEEF with HREADYOUT=1 on the 4th data-phase cycle.
REQ-035 Back-to-back: a byte write at 0x3 issued in the DONE cycle of a prior read -> second transfer enters WDATA directly, ahbsram_size=000, ahbsram_addr=0x3, no IDLE cycle in between.
REQ-036 Errors: HSIZE=011, then a halfword at 0x1 -> each gives ERR1/ERR2 (HRESP=1 for 2 cycles, HREADYOUT 0 then 1), ahbsram_req never asserted.
REQ-037 Slow ack: ack delayed 5 cycles -> HREADYOUT stays 0 throughout, single ahbsram_req pulse, completion on the cycle after ack.
REQ-038 Reset mid-WAIT: HRESETN=0 asserted in WAIT -> HREADYOUT=1 and ahbsram_req=0 immediately; a late ack after release is ignored and the state stays IDLE.
